// File: rtl/sdram_arb_pkg.sv
// Shared encodings for the SDRAM request arbiter: command opcodes, FSM states
// and the saturating refresh-pending update.
package sdram_arb_pkg;

    localparam int unsigned OP_W     = 2;
    localparam int unsigned PEND_W   = 4;
    localparam int unsigned PEND_MAX = 15;

    typedef enum logic [OP_W-1:0] {
        OP_IDLE = 2'b00,
        OP_WR   = 2'b01,
        OP_RD   = 2'b10,
        OP_REF  = 2'b11
    } cmd_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_BUSY  = 2'b10
    } arb_state_e;

    // An increment and a decrement in the same cycle cancel out.
    function automatic logic [PEND_W-1:0] pend_next(
        input logic [PEND_W-1:0] pend,
        input logic              inc,
        input logic              dec
    );
        logic [PEND_W-1:0] res;
        res = pend;
        if (inc && !dec && (pend != PEND_W'(PEND_MAX))) begin
            res = pend + PEND_W'(1);
        end else if (dec && !inc && (pend != '0)) begin
            res = pend - PEND_W'(1);
        end
        return res;
    endfunction

endpackage

// File: rtl/sdram_ref_timer.sv
// Auto-refresh obligation timer: interval counter plus saturating count of
// refreshes owed to the SDRAM, with an urgency flag.
module sdram_ref_timer
    import sdram_arb_pkg::*;
#(
    parameter int unsigned REF_INTERVAL = 781,
    parameter int unsigned REF_MAX_PEND = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic              ref_ack_i,
    output logic [PEND_W-1:0] ref_pend_o,
    output logic              urgent_o
);

    localparam int unsigned CNT_W = (REF_INTERVAL > 1) ? $clog2(REF_INTERVAL) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REF_INTERVAL - 1);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic              urgent_q, urgent_d;
    logic              tick;

    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (en_i) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
                tick  = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        pend_d   = pend_next(pend_q, tick, ref_ack_i);
        // Registered alongside the count so it always reflects ref_pend_o.
        urgent_d = (pend_d >= PEND_W'(REF_MAX_PEND));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q    <= '0;
            pend_q   <= '0;
            urgent_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
            urgent_q <= urgent_d;
        end
    end

    assign ref_pend_o = pend_q;
    assign urgent_o   = urgent_q;

endmodule

// File: rtl/sdram_req_arbiter.sv
// Serialises write bursts, read bursts and auto-refresh onto a single
// command handshake to the SDRAM controller, one command in flight.
module sdram_req_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W       = 21,
    parameter int unsigned LEN_W        = 9,
    parameter int unsigned REF_INTERVAL = 781,
    parameter int unsigned REF_MAX_PEND = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              init_done_i,

    input  logic              wr_req_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [LEN_W-1:0]  wr_len_i,
    output logic              wr_gnt_o,
    output logic              wr_done_o,

    input  logic              rd_req_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    input  logic [LEN_W-1:0]  rd_len_i,
    output logic              rd_gnt_o,
    output logic              rd_done_o,

    output logic              cmd_valid_o,
    input  logic              cmd_ready_i,
    output logic [OP_W-1:0]   cmd_op_o,
    output logic [ADDR_W-1:0] cmd_addr_o,
    output logic [LEN_W-1:0]  cmd_len_o,
    input  logic              cmd_done_i,

    output logic [PEND_W-1:0] ref_pend_o
);

    arb_state_e        state_q, state_d;
    cmd_op_e           op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic              rr_rd_q, rr_rd_d;

    logic              wr_gnt_q, wr_gnt_d;
    logic              wr_done_q, wr_done_d;
    logic              rd_gnt_q, rd_gnt_d;
    logic              rd_done_q, rd_done_d;
    logic              cmd_valid_q, cmd_valid_d;
    cmd_op_e           cmd_op_q, cmd_op_d;
    logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
    logic [LEN_W-1:0]  cmd_len_q, cmd_len_d;

    logic              urgent;
    logic              ref_ack;
    logic              grant_en;
    logic              sel_wr, sel_rd, sel_ref;

    sdram_ref_timer #(
        .REF_INTERVAL (REF_INTERVAL),
        .REF_MAX_PEND (REF_MAX_PEND)
    ) u_ref_timer (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .en_i       (init_done_i),
        .ref_ack_i  (ref_ack),
        .ref_pend_o (ref_pend_o),
        .urgent_o   (urgent)
    );

    // A done pulse on the bus means the requester has not yet dropped its
    // level request, so no decision is taken in that cycle.
    assign grant_en = init_done_i && !wr_done_q && !rd_done_q;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        len_d       = len_q;
        rr_rd_d     = rr_rd_q;
        wr_gnt_d    = 1'b0;
        wr_done_d   = 1'b0;
        rd_gnt_d    = 1'b0;
        rd_done_d   = 1'b0;
        cmd_valid_d = cmd_valid_q;
        cmd_op_d    = cmd_op_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_len_d   = cmd_len_q;
        ref_ack     = 1'b0;
        sel_wr      = 1'b0;
        sel_rd      = 1'b0;
        sel_ref     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (grant_en) begin
                    if (urgent) begin
                        sel_ref = 1'b1;
                    end else if (wr_req_i && !rd_req_i) begin
                        sel_wr = 1'b1;
                    end else if (rd_req_i && !wr_req_i) begin
                        sel_rd = 1'b1;
                    end else if (rd_req_i && wr_req_i) begin
                        sel_rd  = rr_rd_q;
                        sel_wr  = !rr_rd_q;
                        rr_rd_d = !rr_rd_q;
                    end else if (ref_pend_o != '0) begin
                        sel_ref = 1'b1;
                    end
                end

                // Zero-length bursts complete immediately without touching the controller.
                if (sel_wr) begin
                    wr_gnt_d = 1'b1;
                    if (wr_len_i == '0) begin
                        wr_done_d = 1'b1;
                    end else begin
                        state_d = ST_ISSUE;
                        op_d    = OP_WR;
                        addr_d  = wr_addr_i;
                        len_d   = wr_len_i;
                    end
                end
                if (sel_rd) begin
                    rd_gnt_d = 1'b1;
                    if (rd_len_i == '0) begin
                        rd_done_d = 1'b1;
                    end else begin
                        state_d = ST_ISSUE;
                        op_d    = OP_RD;
                        addr_d  = rd_addr_i;
                        len_d   = rd_len_i;
                    end
                end
                if (sel_ref) begin
                    state_d = ST_ISSUE;
                    op_d    = OP_REF;
                    addr_d  = '0;
                    len_d   = '0;
                end
            end

            ST_ISSUE: begin
                if (!cmd_valid_q) begin
                    cmd_valid_d = 1'b1;
                    cmd_op_d    = op_q;
                    cmd_addr_d  = addr_q;
                    cmd_len_d   = len_q;
                end else if (cmd_ready_i) begin
                    cmd_valid_d = 1'b0;
                    cmd_op_d    = OP_IDLE;
                    cmd_addr_d  = '0;
                    cmd_len_d   = '0;
                    state_d     = ST_BUSY;
                end
            end

            ST_BUSY: begin
                if (cmd_done_i) begin
                    state_d = ST_IDLE;
                    case (op_q)
                        OP_WR:   wr_done_d = 1'b1;
                        OP_RD:   rd_done_d = 1'b1;
                        OP_REF:  ref_ack   = 1'b1;
                        default: ;
                    endcase
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_IDLE;
            addr_q      <= '0;
            len_q       <= '0;
            rr_rd_q     <= 1'b1;
            wr_gnt_q    <= 1'b0;
            wr_done_q   <= 1'b0;
            rd_gnt_q    <= 1'b0;
            rd_done_q   <= 1'b0;
            cmd_valid_q <= 1'b0;
            cmd_op_q    <= OP_IDLE;
            cmd_addr_q  <= '0;
            cmd_len_q   <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            rr_rd_q     <= rr_rd_d;
            wr_gnt_q    <= wr_gnt_d;
            wr_done_q   <= wr_done_d;
            rd_gnt_q    <= rd_gnt_d;
            rd_done_q   <= rd_done_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_op_q    <= cmd_op_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_len_q   <= cmd_len_d;
        end
    end

    assign wr_gnt_o    = wr_gnt_q;
    assign wr_done_o   = wr_done_q;
    assign rd_gnt_o    = rd_gnt_q;
    assign rd_done_o   = rd_done_q;
    assign cmd_valid_o = cmd_valid_q;
    assign cmd_op_o    = cmd_op_q;
    assign cmd_addr_o  = cmd_addr_q;
    assign cmd_len_o   = cmd_len_q;

endmodule

// File: tb/tb_sdram_req_arbiter.sv
// Randomised bench for sdram_req_arbiter: requester/controller models drive
// the DUT and every output is compared each cycle with a behavioural model.
module tb_sdram_req_arbiter;

    localparam int unsigned ADDR_W       = 21;
    localparam int unsigned LEN_W        = 9;
    localparam int unsigned REF_INTERVAL = 10;
    localparam int unsigned REF_MAX_PEND = 2;
    localparam int          N_CYC        = 4000;

    logic              clk = 1'b0;
    logic              rst, init_done;
    logic              wr_req, rd_req;
    logic [ADDR_W-1:0] wr_addr, rd_addr;
    logic [LEN_W-1:0]  wr_len, rd_len;
    logic              wr_gnt, wr_done, rd_gnt, rd_done;
    logic              cmd_valid, cmd_ready, cmd_done;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_len;
    logic [3:0]        ref_pend;

    always #5 clk = ~clk;

    sdram_req_arbiter #(
        .ADDR_W       (ADDR_W),
        .LEN_W        (LEN_W),
        .REF_INTERVAL (REF_INTERVAL),
        .REF_MAX_PEND (REF_MAX_PEND)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .init_done_i (init_done),
        .wr_req_i    (wr_req),
        .wr_addr_i   (wr_addr),
        .wr_len_i    (wr_len),
        .wr_gnt_o    (wr_gnt),
        .wr_done_o   (wr_done),
        .rd_req_i    (rd_req),
        .rd_addr_i   (rd_addr),
        .rd_len_i    (rd_len),
        .rd_gnt_o    (rd_gnt),
        .rd_done_o   (rd_done),
        .cmd_valid_o (cmd_valid),
        .cmd_ready_i (cmd_ready),
        .cmd_op_o    (cmd_op),
        .cmd_addr_o  (cmd_addr),
        .cmd_len_o   (cmd_len),
        .cmd_done_i  (cmd_done),
        .ref_pend_o  (ref_pend)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: phase 0 idle, 1 granted, 2 offered, 3 executing.
    int unsigned m_tmr, m_pend, m_op, m_addr, m_len;
    int          m_phase;
    bit          m_rr_rd;
    int unsigned e_wr_gnt, e_wr_done, e_rd_gnt, e_rd_done;
    int unsigned e_valid, e_op, e_addr, e_len;

    task automatic model_step();
        int unsigned n_tmr, n_wr_gnt, n_wr_done, n_rd_gnt, n_rd_done;
        int          n_pend, choice;
        bit          inc, dec;
        if (rst) begin
            m_tmr = 0; m_pend = 0; m_rr_rd = 1'b1; m_phase = 0;
            m_op = 0; m_addr = 0; m_len = 0;
            e_wr_gnt = 0; e_wr_done = 0; e_rd_gnt = 0; e_rd_done = 0;
            e_valid = 0; e_op = 0; e_addr = 0; e_len = 0;
            return;
        end
        inc = 1'b0;
        n_tmr = m_tmr;
        if (init_done) begin
            if (m_tmr == REF_INTERVAL - 1) begin
                n_tmr = 0;
                inc = 1'b1;
            end else begin
                n_tmr = m_tmr + 1;
            end
        end
        dec = (m_phase == 3) && cmd_done && (m_op == 3);
        n_pend = int'(m_pend) + (inc ? 1 : 0) - (dec ? 1 : 0);
        if (n_pend > 15) n_pend = 15;
        if (n_pend < 0) n_pend = 0;
        n_wr_gnt = 0; n_wr_done = 0; n_rd_gnt = 0; n_rd_done = 0;
        case (m_phase)
            0: begin
                if (init_done && e_wr_done == 0 && e_rd_done == 0) begin
                    choice = 0;
                    if (m_pend >= REF_MAX_PEND) choice = 3;
                    else if (wr_req && !rd_req) choice = 1;
                    else if (rd_req && !wr_req) choice = 2;
                    else if (rd_req && wr_req) begin
                        choice  = m_rr_rd ? 2 : 1;
                        m_rr_rd = !m_rr_rd;
                    end else if (m_pend > 0) choice = 3;
                    if (choice == 1) begin
                        n_wr_gnt = 1;
                        if (wr_len == 0) n_wr_done = 1;
                        else begin
                            m_phase = 1; m_op = 1;
                            m_addr = 32'(wr_addr); m_len = 32'(wr_len);
                        end
                    end
                    if (choice == 2) begin
                        n_rd_gnt = 1;
                        if (rd_len == 0) n_rd_done = 1;
                        else begin
                            m_phase = 1; m_op = 2;
                            m_addr = 32'(rd_addr); m_len = 32'(rd_len);
                        end
                    end
                    if (choice == 3) begin
                        m_phase = 1; m_op = 3; m_addr = 0; m_len = 0;
                    end
                end
            end
            1: begin
                e_valid = 1; e_op = m_op; e_addr = m_addr; e_len = m_len;
                m_phase = 2;
            end
            2: begin
                if (cmd_ready) begin
                    e_valid = 0; e_op = 0; e_addr = 0; e_len = 0;
                    m_phase = 3;
                end
            end
            default: begin
                if (cmd_done) begin
                    m_phase = 0;
                    if (m_op == 1) n_wr_done = 1;
                    else if (m_op == 2) n_rd_done = 1;
                end
            end
        endcase
        m_tmr = n_tmr;
        m_pend = 32'(n_pend);
        e_wr_gnt = n_wr_gnt; e_wr_done = n_wr_done;
        e_rd_gnt = n_rd_gnt; e_rd_done = n_rd_done;
    endtask

    task automatic compare_all();
        chk("wr_gnt",    32'(wr_gnt),    e_wr_gnt);
        chk("wr_done",   32'(wr_done),   e_wr_done);
        chk("rd_gnt",    32'(rd_gnt),    e_rd_gnt);
        chk("rd_done",   32'(rd_done),   e_rd_done);
        chk("cmd_valid", 32'(cmd_valid), e_valid);
        chk("cmd_op",    32'(cmd_op),    e_op);
        chk("cmd_addr",  32'(cmd_addr),  e_addr);
        chk("cmd_len",   32'(cmd_len),   e_len);
        chk("ref_pend",  32'(ref_pend),  m_pend);
    endtask

    // Requester and controller behaviour.
    bit wr_granted, rd_granted, ctl_busy;
    int ctl_wait, init_low;
    int n_ref_ops, n_zero, n_bursts;

    function automatic logic [LEN_W-1:0] pick_len();
        if ($urandom_range(0, 7) == 0) return '0;
        return LEN_W'($urandom_range(1, 511));
    endfunction

    task automatic drive(input int c);
        int lat;
        cmd_done = 1'b0;
        if (c < 3 || (c >= 2000 && c < 2002)) begin
            rst = 1'b1; init_done = 1'b0;
            wr_req = 1'b0; rd_req = 1'b0; cmd_ready = 1'b0;
            wr_granted = 1'b0; rd_granted = 1'b0; ctl_busy = 1'b0;
            return;
        end
        rst = 1'b0;

        if (wr_gnt) wr_granted = 1'b1;
        if (rd_gnt) rd_granted = 1'b1;
        if (wr_gnt && wr_done) n_zero++;
        if (rd_gnt && rd_done) n_zero++;
        if (wr_done) begin wr_req = 1'b0; wr_granted = 1'b0; end
        if (rd_done) begin rd_req = 1'b0; rd_granted = 1'b0; end

        if (c < 53) init_done = 1'b0;
        else if (c < 420) init_done = 1'b1;
        else if (init_low > 0) begin
            init_done = 1'b0;
            init_low--;
        end else begin
            init_done = 1'b1;
            if ($urandom_range(0, 99) == 0) init_low = $urandom_range(1, 12);
        end

        if (ctl_busy) begin
            if (ctl_wait == 0) begin
                cmd_done = 1'b1;
                ctl_busy = 1'b0;
            end else begin
                ctl_wait--;
            end
        end else if (c >= 420 && !cmd_valid && $urandom_range(0, 19) == 0) begin
            cmd_done = 1'b1;
        end

        if (c < 420) cmd_ready = 1'b1;
        else if (c >= 3000 && c < 3600) cmd_ready = ((c % 8) >= 5);
        else cmd_ready = ($urandom_range(0, 3) != 0);

        if (cmd_valid && cmd_ready) begin
            if (cmd_op == 2'b11) n_ref_ops++;
            else n_bursts++;
            if (c < 420) lat = (cmd_op == 2'b11) ? 1 : 299;
            else if (cmd_op == 2'b11) lat = $urandom_range(0, 3);
            else if ($urandom_range(0, 15) == 0) lat = $urandom_range(20, 40);
            else lat = $urandom_range(0, 10);
            ctl_busy = 1'b1;
            ctl_wait = lat;
        end

        if (c == 3) begin
            wr_req = 1'b1; wr_addr = ADDR_W'(32'h00100); wr_len = LEN_W'(256);
        end else if (c >= 420) begin
            if (wr_req && !wr_granted && $urandom_range(0, 49) == 0) wr_req = 1'b0;
            else if (!wr_req && $urandom_range(0, 3) == 0) begin
                wr_req = 1'b1; wr_addr = ADDR_W'($urandom); wr_len = pick_len();
            end
            if (rd_req && !rd_granted && $urandom_range(0, 49) == 0) rd_req = 1'b0;
            else if (!rd_req && $urandom_range(0, 3) == 0) begin
                rd_req = 1'b1; rd_addr = ADDR_W'($urandom); rd_len = pick_len();
            end
        end
    endtask

    initial begin
        bit armed;
        armed = 1'b0;
        rst = 1'b1; init_done = 1'b0;
        wr_req = 1'b0; rd_req = 1'b0; cmd_ready = 1'b0; cmd_done = 1'b0;
        wr_addr = '0; rd_addr = '0; wr_len = '0; rd_len = '0;
        wr_granted = 1'b0; rd_granted = 1'b0; ctl_busy = 1'b0;
        ctl_wait = 0; init_low = 0; n_ref_ops = 0; n_zero = 0; n_bursts = 0;
        for (int c = 0; c < N_CYC; c++) begin
            @(negedge clk);
            if (armed) compare_all();
            drive(c);
            model_step();
            armed = 1'b1;
        end
        chk("refresh_issued", 32'(n_ref_ops != 0), 32'd1);
        chk("bursts_issued",  32'(n_bursts != 0),  32'd1);
        chk("zero_len_seen",  32'(n_zero != 0),    32'd1);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
